// File: rtl/debounce_pkg.sv
// Shared debounce types and defaults.
// State codes plus settle-count constants reused by single-button debouncers.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_COMMIT = 2'b10
  } state_e;

  localparam int unsigned DEF_COUNT   = 1000000;
  localparam int unsigned DEF_COUNT_W = 20;

endpackage

// File: rtl/shared_debounce_scheduler_sync.sv
// N-wide two-flop synchronizer for raw button pins.
// Synchronous active-high reset clears both stages.
module btn_sync_bank #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] s1_q, s1_d;
  logic [N-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/shared_debounce_scheduler.sv
// Debounces N buttons with one settle counter shared round-robin.
// A button owns the counter until its change commits or reverts.
module shared_debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int          N       = 4,
  parameter int          IDX_W   = 2,
  parameter int unsigned COUNT   = DEF_COUNT,
  parameter int          COUNT_W = DEF_COUNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     btn_raw,
  output logic [N-1:0]     btn_out,
  output logic [N-1:0]     btn_press,
  output logic             busy,
  output logic [IDX_W-1:0] active_idx
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cand_q, cand_d;
  logic [N-1:0]       out_q, out_d;
  logic [N-1:0]       press_q, press_d;

  logic [N-1:0]       btn_sync;
  logic [N-1:0]       diff;
  logic [2*N-1:0]     rot2;
  logic [N-1:0]       rot;
  logic               found;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     gsum;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   nxt;

  btn_sync_bank #(.N(N)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  assign diff = btn_sync ^ out_q;

  // Rotate so bit 0 is rr_q; lowest set bit is the circular winner.
  always_comb begin
    rot2  = {diff, diff} >> rr_q;
    rot   = rot2[N-1:0];
    found = |rot;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
    gsum = {1'b0, rr_q} + {1'b0, off};
    if (gsum >= (IDX_W+1)'(N)) gsum = gsum - (IDX_W+1)'(N);
    grant = gsum[IDX_W-1:0];
  end

  assign nxt = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    cand_d  = cand_q;
    out_d   = out_q;
    press_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          idx_d   = grant;
          cand_d  = btn_sync[grant];
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (btn_sync[idx_q] != cand_q) begin
          state_d = ST_IDLE;
          rr_d    = nxt;
          cnt_d   = '0;
        end else if (cnt_q == COUNT_W'(COUNT - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        out_d[idx_q]   = cand_q;
        press_d[idx_q] = cand_q;
        rr_d           = nxt;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      idx_q   <= '0;
      cand_q  <= 1'b0;
      out_q   <= '0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      cand_q  <= cand_d;
      out_q   <= out_d;
      press_q <= press_d;
    end
  end

  assign btn_out    = out_q;
  assign btn_press  = press_q;
  assign busy       = (state_q != ST_IDLE);
  assign active_idx = idx_q;

endmodule
